// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - op codes, funct codes and state encoding for the multiply/divide unit
package mul_div_unit_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_MUL  = 2'd1,
    MDU_ST_DIV  = 2'd2
  } mdu_state_e;

  function automatic logic mdu_is_mul(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic mdu_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - conditional two's-complement negate, used for operand abs and result sign fix-up
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + {{(W-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative shift-add multiply / restoring divide with HI/LO registers
// Optional divide-by-zero flag output div0 enabled by MDU_DIV0_FLAG_EN.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             cancel,
`ifdef MDU_DIV0_FLAG_EN
  output logic             div0,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             negp_q, negp_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last;
  logic             sa, sb;
  logic [WIDTH-1:0] rs_abs, rt_abs;

  assign accept = (state_q == MDU_ST_IDLE) && start && !cancel;
  assign last   = (cnt_q == CNT_LAST);
  assign sa     = mdu_is_signed(op) & rs[WIDTH-1];
  assign sb     = mdu_is_signed(op) & rt[WIDTH-1];

  mdu_sign_fix #(.W(WIDTH)) u_abs_rs (.val(rs), .neg(sa), .res(rs_abs));
  mdu_sign_fix #(.W(WIDTH)) u_abs_rt (.val(rt), .neg(sb), .res(rt_abs));

  // Multiply step: {acc, work} is the running product, work holds the unconsumed multiplier bits.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc, mul_work;
  assign mul_sum  = {1'b0, acc_q} + (work_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign mul_acc  = mul_sum[WIDTH:1];
  assign mul_work = {mul_sum[0], work_q[WIDTH-1:1]};

  // Divide step: acc is the partial remainder, work shifts the dividend out and quotient bits in.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc, div_work;
  assign div_shift = {acc_q, work_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_acc   = div_ge ? (div_shift[WIDTH-1:0] - opb_q) : div_shift[WIDTH-1:0];
  assign div_work  = {work_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (.val({mul_acc, mul_work}), .neg(negp_q), .res(prod_fix));
  mdu_sign_fix #(.W(WIDTH))   u_fix_quo  (.val(div_work), .neg(negp_q), .res(quo_fix));
  mdu_sign_fix #(.W(WIDTH))   u_fix_rem  (.val(div_acc),  .neg(negr_q), .res(rem_fix));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MDU_ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_ST_IDLE: begin
        if (accept && mdu_is_mul(op))      state_d = MDU_ST_MUL;
        else if (accept && mdu_is_div(op)) state_d = MDU_ST_DIV;
      end
      MDU_ST_MUL, MDU_ST_DIV: begin
        if (cancel || last) state_d = MDU_ST_IDLE;
      end
      default: state_d = MDU_ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != MDU_ST_IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    work_d = work_q;
    opb_d  = opb_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    negp_d = negp_q;
    negr_d = negr_q;
    dz_d   = dz_q;
    done_d = 1'b0;
    case (state_q)
      MDU_ST_IDLE: begin
        if (accept && (mdu_is_mul(op) || mdu_is_div(op))) begin
          cnt_d  = '0;
          acc_d  = '0;
          negp_d = sa ^ sb;
          negr_d = sa;
          dz_d   = (rt == '0);
          work_d = mdu_is_mul(op) ? rt_abs : rs_abs;
          opb_d  = mdu_is_mul(op) ? rs_abs : rt_abs;
        end else if (accept && (op == MDU_MTHI)) begin
          hi_d = rs;
        end else if (accept && (op == MDU_MTLO)) begin
          lo_d = rs;
        end
      end
      MDU_ST_MUL: begin
        if (!cancel) begin
          acc_d  = mul_acc;
          work_d = mul_work;
          cnt_d  = last ? '0 : cnt_q + 1'b1;
          if (last) begin
            {hi_d, lo_d} = prod_fix;
            done_d       = 1'b1;
          end
        end
      end
      MDU_ST_DIV: begin
        if (!cancel) begin
          acc_d  = div_acc;
          work_d = div_work;
          cnt_d  = last ? '0 : cnt_q + 1'b1;
          if (last) begin
            // A zero divisor leaves the remainder equal to rs; the quotient is forced to all-ones.
            hi_d   = rem_fix;
            lo_d   = dz_q ? '1 : quo_fix;
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      work_q <= '0;
      opb_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      negp_q <= 1'b0;
      negr_q <= 1'b0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      work_q <= work_d;
      opb_q  <= opb_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      negp_q <= negp_d;
      negr_q <= negr_d;
      dz_q   <= dz_d;
      done_q <= done_d;
    end
  end

`ifdef MDU_DIV0_FLAG_EN
  logic div0_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div0_q <= 1'b0;
    end else if (accept && (mdu_is_mul(op) || mdu_is_div(op))) begin
      div0_q <= 1'b0;
    end else if ((state_q == MDU_ST_DIV) && !cancel && last) begin
      div0_q <= dz_q;
    end
  end

  assign div0 = div0_q;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef MDU_DIV0_FLAG_EN
  logic        div0;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int overlap = 0;

  mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs(rs), .rt(rt), .cancel(cancel),
`ifdef MDU_DIV0_FLAG_EN
    .div0(div0),
`endif
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlap++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output logic d);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    d = done;
  endtask

  task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int   cyc;
    logic d;
    issue(o, a, b);
    wait_done(cyc, d);
    check({tag, " busy_cycles"}, 64'(cyc), 64'd32);
    check({tag, " done"}, 64'(d), 64'd1);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    @(negedge clk);
    check({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int   cyc;
    logic d;
    int   seen;

    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; rs = '0; rt = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    rst = 1'b0;

    run_md("mult -3*5", MDU_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_md("multu max*max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_md("div -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`ifdef MDU_DIV0_FLAG_EN
    check("div0 clear after div", 64'(div0), 64'd0);
`endif
    run_md("divu 100/0", MDU_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
`ifdef MDU_DIV0_FLAG_EN
    check("div0 set", 64'(div0), 64'd1);
`endif
    run_md("div -7/0", MDU_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_md("div minint/-1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
`ifdef MDU_DIV0_FLAG_EN
    check("div0 cleared by start", 64'(div0), 64'd0);
`endif
    run_md("divu 100/7", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    // MTHI then MTLO on consecutive cycles
    @(negedge clk);
    start = 1'b1; op = MDU_MTHI; rs = 32'h1234_5678;
    @(negedge clk);
    check("mthi hi", 64'(hi), 64'h1234_5678);
    check("mthi busy", 64'(busy), 64'd0);
    op = MDU_MTLO; rs = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo lo", 64'(lo), 64'h9ABC_DEF0);
    check("mtlo hi", 64'(hi), 64'h1234_5678);
    check("mtlo busy", 64'(busy), 64'd0);
    check("mtlo done", 64'(done), 64'd0);

    // cancel at busy cycle 10
    issue(MDU_MULT, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    check("cancel pre busy", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    check("cancel no done", 64'(seen), 64'd0);
    check("cancel hi", 64'(hi), 64'h1234_5678);
    check("cancel lo", 64'(lo), 64'h9ABC_DEF0);

    // cancel in IDLE wins over a coincident start
    @(negedge clk);
    start = 1'b1; op = MDU_MULT; rs = 32'd3; rt = 32'd3; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("idle cancel busy", 64'(busy), 64'd0);

    // start while busy is ignored
    issue(MDU_MULTU, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    start = 1'b1; op = MDU_MTHI; rs = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, d);
    check("busy start done", 64'(d), 64'd1);
    check("busy start hi", 64'(hi), 64'd0);
    check("busy start lo", 64'(lo), 64'd12);

    // undefined op is ignored
    issue(3'd7, 32'h5555_5555, 32'd1);
    check("undef busy", 64'(busy), 64'd0);
    check("undef hi", 64'(hi), 64'd0);
    check("undef lo", 64'(lo), 64'd12);

    // asynchronous reset mid-operation
    issue(MDU_MULT, 32'd5, 32'd5);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst done", 64'(done), 64'd0);
    check("async rst hi", 64'(hi), 64'd0);
    check("async rst lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_md("mult 6*7", MDU_MULT, 32'd6, 32'd7, 32'd0, 32'd42);

    check("busy/done overlap", 64'(overlap), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
